// File: rtl/slc3_pkg.sv
// Shared types and defaults for the SLC-3 memory-side logic.
package slc3_pkg;

  // Memory responder FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  // Memory-mapped I/O word: switches on read, hex display on write.
  localparam logic [15:0] SLC3_IO_ADDR = 16'hFFFF;

  // Default number of SRAM access cycles per request.
  localparam int SLC3_WAIT_STATES = 2;

endpackage

// File: rtl/register.sv
// Generic N-bit load-enable register with synchronous active-high clear.
module register #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         load,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout
);

  // Clear has priority so a load presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (srst) begin
      dout <= '0;
    end else if (load) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/slc3_mem_responder.sv
// SLC-3 memory responder: serves CPU MAR/MDR requests from a synchronous
// SRAM with fixed wait states, decodes one I/O word (switches / hex display)
// and completes each request with a four-phase MEM_READY handshake.
module slc3_mem_responder
  import slc3_pkg::*;
#(
  parameter int          WAIT_STATES = SLC3_WAIT_STATES,
  parameter logic [15:0] IO_ADDR     = SLC3_IO_ADDR
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  input  logic        MEM_OE,
  input  logic        MEM_WE,
  output logic [15:0] MDR_In,
  output logic        MEM_READY,
  input  logic [15:0] SW,
  output logic [15:0] HEX_DATA,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_wdata,
  input  logic [15:0] sram_rdata,
  output logic        sram_ce,
  output logic        sram_we
);

  localparam int CNT_W = $clog2(WAIT_STATES + 1);

  mem_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             wr_reg, wr_next;
  logic [15:0]      mdr_in_reg, mdr_in_next;
  logic [15:0]      addr_reg, addr_next;
  logic [15:0]      wdata_reg, wdata_next;
  logic             ready_reg, ready_next;
  logic             ce_reg, ce_next;
  logic             we_reg, we_next;
  logic             req;
  logic             hex_load;

  assign req = MEM_OE | MEM_WE;

  // State and output registers; every output is driven from here.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      wr_reg     <= 1'b0;
      mdr_in_reg <= 16'h0000;
      addr_reg   <= 16'h0000;
      wdata_reg  <= 16'h0000;
      ready_reg  <= 1'b0;
      ce_reg     <= 1'b0;
      we_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      wr_reg     <= wr_next;
      mdr_in_reg <= mdr_in_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      ready_reg  <= ready_next;
      ce_reg     <= ce_next;
      we_reg     <= we_next;
    end
  end

  // Next-state and next-output logic; registers hold unless a branch updates them.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    wr_next     = wr_reg;
    mdr_in_next = mdr_in_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    ready_next  = ready_reg;
    ce_next     = ce_reg;
    we_next     = we_reg;
    hex_load    = 1'b0;

    case (state_reg)
      IDLE: begin
        ready_next = 1'b0;
        ce_next    = 1'b0;
        we_next    = 1'b0;
        if (req) begin
          // Write wins when both strobes are up.
          wr_next = MEM_WE;
          if (MAR == IO_ADDR) begin
            // I/O word is served on the acceptance edge; the SRAM word it
            // shadows is never touched.
            if (MEM_WE) begin
              hex_load = 1'b1;
            end else begin
              mdr_in_next = SW;
            end
            ready_next = 1'b1;
            state_next = DONE;
          end else begin
            addr_next  = MAR;
            wdata_next = MDR;
            cnt_next   = CNT_W'(WAIT_STATES - 1);
            ce_next    = 1'b1;
            we_next    = MEM_WE;
            state_next = ACCESS;
          end
        end
      end

      ACCESS: begin
        if (cnt_reg == '0) begin
          // Final access edge: SRAM data is guaranteed valid here.
          if (!wr_reg) begin
            mdr_in_next = sram_rdata;
          end
          ce_next    = 1'b0;
          we_next    = 1'b0;
          ready_next = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      DONE: begin
        ready_next = 1'b1;
        ce_next    = 1'b0;
        we_next    = 1'b0;
        // Hold until the CPU withdraws the request so one request = one access.
        if (!req) begin
          ready_next = 1'b0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Hex display register, loaded only by an accepted I/O write.
  register #(
    .N(16)
  ) hex_reg (
    .clk (Clk),
    .srst(Reset),
    .load(hex_load),
    .din (MDR),
    .dout(HEX_DATA)
  );

  assign MDR_In     = mdr_in_reg;
  assign MEM_READY  = ready_reg;
  assign sram_addr  = addr_reg;
  assign sram_wdata = wdata_reg;
  assign sram_ce    = ce_reg;
  assign sram_we    = we_reg;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Bench for slc3_mem_responder: directed requests, a transaction-level
// timing model checked every cycle, and literal expectations per request.
module tb_slc3_mem_responder;
  import slc3_pkg::*;

  localparam int          WS  = 2;
  localparam logic [15:0] IOA = 16'hFFFF;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] MAR = 16'h0000;
  logic [15:0] MDR = 16'h0000;
  logic        MEM_OE = 1'b0;
  logic        MEM_WE = 1'b0;
  logic [15:0] SW = 16'h0000;
  logic [15:0] MDR_In;
  logic        MEM_READY;
  logic [15:0] HEX_DATA;
  logic [15:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata;
  logic        sram_ce;
  logic        sram_we;

  always #5 Clk = ~Clk;

  slc3_mem_responder #(
    .WAIT_STATES(WS),
    .IO_ADDR    (IOA)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .MAR       (MAR),
    .MDR       (MDR),
    .MEM_OE    (MEM_OE),
    .MEM_WE    (MEM_WE),
    .MDR_In    (MDR_In),
    .MEM_READY (MEM_READY),
    .SW        (SW),
    .HEX_DATA  (HEX_DATA),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .sram_ce   (sram_ce),
    .sram_we   (sram_we)
  );

  // Board SRAM model: asynchronous-looking read, writes on the clock.
  logic [15:0] sram_mem [0:65535];
  assign sram_rdata = sram_mem[sram_addr];
  always @(posedge Clk) begin
    if (sram_ce && sram_we) sram_mem[sram_addr] <= sram_wdata;
  end

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  always @(posedge Clk) edge_n <= edge_n + 1;

  // Reference memory contents as the CPU should see them.
  logic [15:0] ref_mem [int];
  function automatic logic [15:0] ref_read(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return a ^ 16'h5A5A;
  endfunction

  // Current transaction record (edge indices are absolute edge numbers).
  bit          chk_en = 1'b0;
  bit          t_valid = 1'b0;
  bit          t_io, t_wr;
  int          t_s, t_drop;
  logic [15:0] t_addr, t_wdata, t_rdata;
  logic [15:0] mdr_base = 16'h0000;
  logic [15:0] hex_base = 16'h0000;
  int          ce_cnt, we_cnt, rdy_cnt;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%h expected=%h", name, edge_n, act, exp);
    end
  endtask

  // Per-cycle compare: outputs after edge k derived from the request's
  // acceptance edge, completion edge and drop edge.
  always @(negedge Clk) begin : cmp
    logic        e_ce, e_we, e_rdy;
    logic [15:0] e_mdr, e_hex;
    int          cd, rdy_end;
    if (sram_ce) ce_cnt++;
    if (sram_we) we_cnt++;
    if (MEM_READY) rdy_cnt++;
    if (chk_en) begin
      e_ce = 1'b0; e_we = 1'b0; e_rdy = 1'b0;
      e_mdr = mdr_base; e_hex = hex_base;
      if (t_valid) begin
        cd = t_io ? t_s : t_s + WS;
        rdy_end = (t_drop > cd) ? t_drop : cd + 1;
        if (!t_io && edge_n >= t_s && edge_n < t_s + WS) begin
          e_ce = 1'b1;
          e_we = t_wr;
        end
        if (edge_n >= cd && edge_n < rdy_end) e_rdy = 1'b1;
        if (edge_n >= cd && !t_wr) e_mdr = t_rdata;
        if (edge_n >= cd && t_wr && t_io) e_hex = t_wdata;
      end
      check("mem_ready", 16'(MEM_READY), 16'(e_rdy));
      check("sram_ce", 16'(sram_ce), 16'(e_ce));
      check("sram_we", 16'(sram_we), 16'(e_we));
      check("mdr_in", MDR_In, e_mdr);
      check("hex_data", HEX_DATA, e_hex);
      if (e_ce) begin
        check("sram_addr", sram_addr, t_addr);
        if (t_wr) check("sram_wdata", sram_wdata, t_wdata);
      end
    end
  end

  task automatic drop_req();
    MEM_OE = 1'b0;
    MEM_WE = 1'b0;
    t_drop = edge_n + 1;
  endtask

  // Issue one request (called #1 after an edge with the DUT idle).
  // hold < 0 drops the request right after acceptance.
  task automatic run_txn(input string tag, input logic [15:0] a, input logic [15:0] d,
                         input logic oe, input logic we, input int hold, output int lat);
    int n;
    int done_e;
    if (t_valid) begin
      if (!t_wr) mdr_base = t_rdata;
      if (t_wr && t_io) hex_base = t_wdata;
    end
    MAR = a; MDR = d; MEM_OE = oe; MEM_WE = we;
    t_io = (a == IOA); t_wr = we; t_s = edge_n + 1; t_drop = 32'h7FFF_FFFF;
    t_addr = a; t_wdata = d;
    t_rdata = t_io ? SW : ref_read(a);
    if (we && !t_io) ref_mem[int'(a)] = d;
    t_valid = 1'b1;
    ce_cnt = 0; we_cnt = 0; rdy_cnt = 0; lat = -1;
    done_e = t_io ? t_s : t_s + WS;
    if (hold < 0) begin
      @(posedge Clk); #1;
      drop_req();
    end
    n = 0;
    while (!MEM_READY && n < 40) begin
      @(posedge Clk); #1;
      n++;
    end
    check({tag, "_ready_seen"}, 16'(MEM_READY), 16'h0001);
    if (MEM_READY) lat = edge_n - t_s + 1;
    if (hold >= 0) begin
      repeat (hold) begin
        @(posedge Clk); #1;
      end
      drop_req();
    end
    n = 0;
    while ((MEM_READY || edge_n <= done_e) && n < 40) begin
      @(posedge Clk); #1;
      n++;
    end
    check({tag, "_ready_fell"}, 16'(MEM_READY), 16'h0000);
    $display("TXN %s addr=%h wdata=%h oe=%0b we=%0b latency=%0d mdr_in=%h hex=%h",
             tag, a, d, oe, we, lat, MDR_In, HEX_DATA);
  endtask

  int lat;

  initial begin
    for (int i = 0; i < 65536; i++) sram_mem[i] = 16'(i) ^ 16'h5A5A;
    sram_mem[16'h3000] = 16'hBEEF;
    ref_mem[32'h3000] = 16'hBEEF;

    // Power-on reset.
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    check("rst_mdr_in", MDR_In, 16'h0000);
    check("rst_hex", HEX_DATA, 16'h0000);
    check("rst_ready", 16'(MEM_READY), 16'h0000);
    check("rst_ce", 16'(sram_ce), 16'h0000);
    check("rst_we", 16'(sram_we), 16'h0000);
    chk_en = 1'b1;
    @(posedge Clk); #1;

    run_txn("sram_read", 16'h3000, 16'h0000, 1'b1, 1'b0, 2, lat);
    check("rd_latency", 16'(lat), 16'd3);
    check("rd_ce_cycles", 16'(ce_cnt), 16'd2);
    check("rd_data", MDR_In, 16'hBEEF);

    run_txn("sram_write", 16'h0042, 16'h1234, 1'b0, 1'b1, 0, lat);
    check("wr_latency", 16'(lat), 16'd3);
    check("wr_ce_cycles", 16'(ce_cnt), 16'd2);
    check("wr_we_cycles", 16'(we_cnt), 16'd2);
    check("wr_mdr_kept", MDR_In, 16'hBEEF);

    SW = 16'h00A5;
    run_txn("io_read", IOA, 16'h0000, 1'b1, 1'b0, 0, lat);
    check("io_rd_latency", 16'(lat), 16'd1);
    check("io_rd_ce_cycles", 16'(ce_cnt), 16'd0);
    check("io_rd_data", MDR_In, 16'h00A5);

    run_txn("io_write", IOA, 16'h0C0D, 1'b0, 1'b1, 0, lat);
    check("io_wr_latency", 16'(lat), 16'd1);
    check("io_wr_hex", HEX_DATA, 16'h0C0D);
    check("io_wr_ce_cycles", 16'(ce_cnt), 16'd0);

    run_txn("both_strobes", 16'h0010, 16'h5555, 1'b1, 1'b1, 1, lat);
    check("both_we_cycles", 16'(we_cnt), 16'd2);
    check("both_mdr_kept", MDR_In, 16'h00A5);

    run_txn("readback_10", 16'h0010, 16'h0000, 1'b1, 1'b0, 0, lat);
    check("readback_10_data", MDR_In, 16'h5555);

    run_txn("readback_42", 16'h0042, 16'h0000, 1'b1, 1'b0, 0, lat);
    check("readback_42_data", MDR_In, 16'h1234);

    run_txn("held_read", 16'h3000, 16'h0000, 1'b1, 1'b0, 10, lat);
    check("held_ce_cycles", 16'(ce_cnt), 16'd2);
    check("held_ready_cycles", 16'(rdy_cnt), 16'd11);
    check("held_data", MDR_In, 16'hBEEF);

    run_txn("early_drop", 16'h0042, 16'h0000, 1'b1, 1'b0, -1, lat);
    check("early_latency", 16'(lat), 16'd3);
    check("early_ready_cycles", 16'(rdy_cnt), 16'd1);
    check("early_data", MDR_In, 16'h1234);

    // Reset in the middle of an SRAM access, with an I/O write pending.
    chk_en = 1'b0;
    MAR = 16'h3000; MEM_OE = 1'b1;
    @(posedge Clk); #1;
    check("mid_ce_before_reset", 16'(sram_ce), 16'h0001);
    Reset = 1'b1; MEM_OE = 1'b0;
    MAR = IOA; MDR = 16'h7777; MEM_WE = 1'b1;
    @(posedge Clk); #1;
    check("mid_rst_state", 16'(dut.state_reg), 16'(IDLE));
    check("mid_rst_ce", 16'(sram_ce), 16'h0000);
    check("mid_rst_ready", 16'(MEM_READY), 16'h0000);
    check("mid_rst_mdr_in", MDR_In, 16'h0000);
    check("mid_rst_hex", HEX_DATA, 16'h0000);
    @(posedge Clk); #1;
    check("mid_rst_hex_held", HEX_DATA, 16'h0000);
    MEM_WE = 1'b0;
    Reset = 1'b0;
    t_valid = 1'b0; mdr_base = 16'h0000; hex_base = 16'h0000;
    @(posedge Clk); #1;
    chk_en = 1'b1;

    run_txn("post_reset_io", IOA, 16'h0000, 1'b1, 1'b0, 0, lat);
    check("post_reset_data", MDR_In, 16'h00A5);
    check("post_reset_hex", HEX_DATA, 16'h0000);

    repeat (2) @(posedge Clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
